// File: rtl/collision_fsm.sv
// Collision/game-state controller: accumulates per-frame sprite contact flags while the
// beam scans, then resolves crash, finish and coin events once per frame at the evaluation pixel.
module collision_fsm #(
  parameter int CRASH_PIX = 16,
  parameter int EVAL_Y    = 481
) (
  input  logic       clk,
  input  logic       reset_game,
  input  logic       start_btn,
  input  logic       active,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       person_on,
  input  logic       path_on,
  input  logic       coin_on,
  input  logic       finish_line,
  output logic       start_en,
  output logic       crash_en,
  output logic       finish_en,
  output logic       pause,
  output logic [7:0] coins,
  output logic       frame_tick
);

  typedef enum logic [1:0] {IDLE, RUN, CRASH, FINISH} state_t;

  localparam logic [9:0] EVAL_ROW  = 10'(EVAL_Y);
  localparam logic [9:0] CRASH_LIM = 10'(CRASH_PIX);

  state_t     state;
  state_t     next_state;
  logic [9:0] sludge_cnt;
  logic       coin_seen;
  logic       finish_seen;
  logic       prev_coin;

  logic eval;
  logic sample;
  logic sludge_hit;
  logic coin_hit;
  logic finish_hit;
  logic crash_cond;
  logic coin_edge;

  assign eval       = (pixel_x == 10'd0) && (pixel_y == EVAL_ROW);
  assign sample     = active & person_on;
  assign sludge_hit = sample & ~path_on & ~coin_on & ~finish_line;
  assign coin_hit   = sample & coin_on;
  assign finish_hit = sample & finish_line;
  assign crash_cond = (sludge_cnt >= CRASH_LIM);
  assign coin_edge  = coin_seen & ~prev_coin;

  // Transitions are only ever taken at the evaluation pixel.
  always_comb begin
    // NOTE: default first so every path assigns next_state; otherwise a latch is inferred.
    next_state = state;
    if (eval) begin
      unique case (state)
        IDLE:   if (start_btn) next_state = RUN;
        RUN: begin
          if (crash_cond)       next_state = CRASH;
          else if (finish_seen) next_state = FINISH;
        end
        CRASH,
        FINISH: if (!start_btn) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_game) begin
      state       <= IDLE;
      start_en    <= 1'b1;
      crash_en    <= 1'b0;
      finish_en   <= 1'b0;
      pause       <= 1'b1;
      coins       <= 8'd0;
      frame_tick  <= 1'b0;
      sludge_cnt  <= 10'd0;
      coin_seen   <= 1'b0;
      finish_seen <= 1'b0;
      prev_coin   <= 1'b0;
    end else begin
      state      <= next_state;
      frame_tick <= eval;
      start_en   <= (next_state == IDLE);
      crash_en   <= (next_state == CRASH);
      finish_en  <= (next_state == FINISH);
      pause      <= (next_state != RUN);

      if (eval) begin
        // A sample on the evaluation pixel opens the next frame's accumulation.
        sludge_cnt  <= sludge_hit ? 10'd1 : 10'd0;
        coin_seen   <= coin_hit;
        finish_seen <= finish_hit;
        prev_coin   <= coin_seen;
        if (state == IDLE && start_btn)
          coins <= 8'd0;
        else if (state == RUN && coin_edge && coins != 8'hFF)
          coins <= coins + 8'd1;
      end else begin
        if (sludge_hit && sludge_cnt != 10'h3FF)
          sludge_cnt <= sludge_cnt + 10'd1;
        if (coin_hit)
          coin_seen <= 1'b1;
        if (finish_hit)
          finish_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_collision_fsm.sv
// Scoreboard bench for collision_fsm: each evaluation pixel queues the expected state/coin
// outputs, and a monitor compares them whenever the DUT raises frame_tick.
module tb_collision_fsm;

  logic       clk = 1'b0;
  logic       reset_game;
  logic       start_btn;
  logic       active;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       person_on;
  logic       path_on;
  logic       coin_on;
  logic       finish_line;
  logic       start_en;
  logic       crash_en;
  logic       finish_en;
  logic       pause;
  logic [7:0] coins;
  logic       frame_tick;

  always #5 clk = ~clk;

  collision_fsm #(.CRASH_PIX(16), .EVAL_Y(481)) dut (
    .clk         (clk),
    .reset_game  (reset_game),
    .start_btn   (start_btn),
    .active      (active),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .person_on   (person_on),
    .path_on     (path_on),
    .coin_on     (coin_on),
    .finish_line (finish_line),
    .start_en    (start_en),
    .crash_en    (crash_en),
    .finish_en   (finish_en),
    .pause       (pause),
    .coins       (coins),
    .frame_tick  (frame_tick)
  );

  localparam int S_IDLE = 0, S_RUN = 1, S_CRASH = 2, S_FINISH = 3;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  wire [11:0] obs = {start_en, crash_en, finish_en, pause, coins};

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {start_en, crash_en, finish_en, pause, coins} for a given state and coin count.
  function automatic logic [11:0] ov(input int s, input int c);
    logic [7:0] cc;
    cc = 8'(c);
    case (s)
      S_IDLE:   return {4'b1001, cc};
      S_RUN:    return {4'b0000, cc};
      S_CRASH:  return {4'b0101, cc};
      default:  return {4'b0011, cc};
    endcase
  endfunction

  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick with outputs %h expected no tick", obs);
      end else begin
        string       t;
        logic [11:0] e;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, obs, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_px();
    active = 1'b1; person_on = 1'b0; path_on = 1'b0; coin_on = 1'b0; finish_line = 1'b0;
    pixel_x = 10'd100; pixel_y = 10'd200;
  endtask

  task automatic pix(input logic a, input logic p, input logic pt, input logic c, input logic f);
    active = a; person_on = p; path_on = pt; coin_on = c; finish_line = f;
    pixel_x = 10'd50; pixel_y = 10'd100;
    cyc();
  endtask

  // One frame body: counted sludge, coin and finish pixels, plus non-counting noise pixels
  // and two near-miss positions next to the evaluation pixel.
  task automatic frame(input int n_sl, input int n_coin, input int n_fin, input int n_noise);
    repeat (n_sl)   pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (n_coin) pix(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (n_fin)  pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (n_noise) begin
      pix(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pix(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle_px(); pixel_x = 10'd0; pixel_y = 10'd480; cyc();
    idle_px(); pixel_x = 10'd1; pixel_y = 10'd481; cyc();
    idle_px();
  endtask

  task automatic eval_pt(input logic start, input logic sl, input string tag, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    start_btn = start;
    active = 1'b1; person_on = sl; path_on = 1'b0; coin_on = 1'b0; finish_line = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd481;
    cyc();
    idle_px();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d expected ticks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset_game = 1'b1;
    start_btn  = 1'b0;
    idle_px();
    cyc(); cyc();
    check("reset_outputs", obs, ov(S_IDLE, 0));
    check("reset_tick", {11'd0, frame_tick}, 12'd0);
    reset_game = 1'b0;

    frame(0, 0, 0, 1);
    eval_pt(1'b0, 1'b0, "idle_no_start", ov(S_IDLE, 0));
    frame(0, 0, 0, 1);
    eval_pt(1'b1, 1'b0, "idle_to_run", ov(S_RUN, 0));
    start_btn = 1'b0;

    // 15 counted sludge pixels (noise pixels never count) stay below the crash threshold.
    frame(15, 0, 0, 2);
    eval_pt(1'b0, 1'b0, "sludge15_run", ov(S_RUN, 0));

    // Coin episodes: frames 1,2 contact, 3 none, 4 contact.
    frame(0, 3, 0, 1);
    eval_pt(1'b0, 1'b0, "coin_f1", ov(S_RUN, 1));
    frame(0, 2, 0, 0);
    eval_pt(1'b0, 1'b0, "coin_f2", ov(S_RUN, 1));
    frame(0, 0, 0, 1);
    eval_pt(1'b0, 1'b0, "coin_f3", ov(S_RUN, 1));
    frame(0, 1, 0, 0);
    eval_pt(1'b0, 1'b0, "coin_f4", ov(S_RUN, 2));

    frame(16, 0, 0, 1);
    eval_pt(1'b0, 1'b0, "sludge16_crash", ov(S_CRASH, 2));
    frame(0, 0, 0, 0);
    eval_pt(1'b0, 1'b0, "crash_to_idle", ov(S_IDLE, 2));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "restart_clears", ov(S_RUN, 0));
    start_btn = 1'b0;

    frame(20, 0, 1, 0);
    eval_pt(1'b0, 1'b0, "crash_over_finish", ov(S_CRASH, 0));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "crash_held", ov(S_CRASH, 0));
    frame(0, 0, 0, 0);
    eval_pt(1'b0, 1'b0, "crash_release", ov(S_IDLE, 0));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "restart2", ov(S_RUN, 0));
    start_btn = 1'b0;

    // Finish with a coin on the same frame: coin still counts on the transition frame.
    frame(0, 2, 2, 1);
    eval_pt(1'b0, 1'b0, "finish_coin", ov(S_FINISH, 1));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "finish_held1", ov(S_FINISH, 1));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "finish_held2", ov(S_FINISH, 1));
    frame(0, 0, 0, 0);
    eval_pt(1'b0, 1'b0, "finish_release", ov(S_IDLE, 1));
    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "finish_restart", ov(S_RUN, 0));
    start_btn = 1'b0;

    // 256 coin episodes: the count saturates at 255.
    for (int i = 1; i <= 256; i++) begin
      int c;
      c = (i > 255) ? 255 : i;
      frame(0, 1, 0, 0);
      eval_pt(1'b0, 1'b0, $sformatf("sat_coin%0d", i), ov(S_RUN, c));
      frame(0, 0, 0, 0);
      eval_pt(1'b0, 1'b0, $sformatf("sat_gap%0d", i), ov(S_RUN, c));
    end

    // Reset asserted on an evaluation pixel with start held: reset wins, no tick, coins dropped.
    frame(0, 0, 0, 0);
    reset_game = 1'b1;
    start_btn  = 1'b1;
    pixel_x = 10'd0; pixel_y = 10'd481; person_on = 1'b1;
    cyc();
    reset_game = 1'b0;
    start_btn  = 1'b0;
    idle_px();
    check("midrun_reset_outputs", obs, ov(S_IDLE, 0));
    check("midrun_reset_tick", {11'd0, frame_tick}, 12'd0);

    frame(0, 0, 0, 0);
    eval_pt(1'b1, 1'b0, "post_reset_start", ov(S_RUN, 0));
    start_btn = 1'b0;
    // One sludge sample on the evaluation pixel belongs to the following frame: 1 + 15 = 16.
    frame(0, 0, 0, 0);
    eval_pt(1'b0, 1'b1, "eval_sample_run", ov(S_RUN, 0));
    frame(15, 0, 0, 0);
    eval_pt(1'b0, 1'b0, "eval_sample_crash", ov(S_CRASH, 0));

    cyc(); cyc();
    check("queue_drained", 12'(exp_q.size()), 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
